// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_EXT  = 1'b1;

    localparam int   DMCTRL_W = 3;
    localparam int   LAT_MAX  = 7;

    // Request fields latched on the grant edge and driven to the DM
    typedef struct packed {
        logic                we;
        logic [31:0]         addr;
        logic [31:0]         wd;
        logic [DMCTRL_W-1:0] ctrl;
        logic [31:0]         pc;
    } dm_req_t;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker; owns the last_grant history bit.
module dm_arb_rr
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,       // [0] = CPU, [1] = EXT
    input  logic       gnt_en,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    // Pick the single requester, or on a tie the port not served last
    always_comb begin
        gnt_valid = |req;
        gnt_id    = GNT_CPU;
        if (req == 2'b11)
            gnt_id = ~last_grant;
        else if (req[1])
            gnt_id = GNT_EXT;
    end

    // Remember who won; reset to EXT so the CPU takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= GNT_EXT;
        else if (gnt_en && gnt_valid)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/dm_arbiter.sv
// CPU / external-port arbiter and fixed-latency access sequencer for the DM.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no access in flight; grant a pending request on this edge
//   ACCESS | DM driven with latched fields; mem_en only in first cycle,
//          | read data captured in the last (cnt == LAT-1) cycle
//   RESP   | one-cycle ack to the granted port, no re-grant
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int LAT = 1
)
(
    input  logic                clk,
    input  logic                reset,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wd,
    input  logic [DMCTRL_W-1:0] cpu_ctrl,
    input  logic [31:0]         cpu_pc,
    output logic                cpu_ack,
    output logic [31:0]         cpu_rd,
    output logic                cpu_stall,

    input  logic                ext_req,
    input  logic                ext_we,
    input  logic [31:0]         ext_addr,
    input  logic [31:0]         ext_wd,
    input  logic [DMCTRL_W-1:0] ext_ctrl,
    output logic                ext_ack,
    output logic [31:0]         ext_rd,

    output logic                mem_en,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wd,
    output logic [DMCTRL_W-1:0] mem_ctrl,
    output logic [31:0]         mem_pc,
    input  logic [31:0]         mem_rd
);

    // Out-of-range LAT is clamped so cnt (3 bits) can never wrap
    localparam int         LAT_EFF  = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 1) ? 1 : LAT);
    localparam logic [2:0] CNT_LAST = 3'(LAT_EFF - 1);

    arb_state_t state;
    logic [2:0] cnt;
    logic       grant;
    dm_req_t    req_q;
    dm_req_t    req_sel;
    logic       gnt_en;
    logic       gnt_valid;
    logic       gnt_id;

    assign gnt_en = (state == IDLE);

    dm_arb_rr u_rr (
        .clk       (clk),
        .rst_n     (reset),
        .req       ({ext_req, cpu_req}),
        .gnt_en    (gnt_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Route the winning port's fields; external grants carry no PC
    always_comb begin
        req_sel = '0;
        if (gnt_id == GNT_CPU) begin
            req_sel.we   = cpu_we;
            req_sel.addr = cpu_addr;
            req_sel.wd   = cpu_wd;
            req_sel.ctrl = cpu_ctrl;
            req_sel.pc   = cpu_pc;
        end else begin
            req_sel.we   = ext_we;
            req_sel.addr = ext_addr;
            req_sel.wd   = ext_wd;
            req_sel.ctrl = ext_ctrl;
            req_sel.pc   = 32'd0;
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wd    = req_q.wd;
    assign mem_ctrl  = req_q.ctrl;
    assign mem_pc    = req_q.pc;

    // The hazard unit needs this before the ack edge, hence combinational
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Arbitration FSM with access counter, request latch and rd/ack registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            grant   <= GNT_CPU;
            req_q   <= '0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ext_ack <= 1'b0;
            cpu_rd  <= 32'd0;
            ext_rd  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        grant  <= gnt_id;
                        req_q  <= req_sel;
                        cnt    <= 3'd0;
                        mem_en <= 1'b1;
                        mem_we <= req_sel.we;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= cnt + 3'd1;
                    if (cnt == CNT_LAST) begin
                        // Stores return zero rather than whatever the DM drives
                        if (grant == GNT_CPU) begin
                            cpu_rd  <= req_q.we ? 32'd0 : mem_rd;
                            cpu_ack <= 1'b1;
                        end else begin
                            ext_rd  <= req_q.we ? 32'd0 : mem_rd;
                            ext_ack <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    ext_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and access sequencer for the single-port data memory behind the MEM stage. It shares the DM between the CPU MEM stage and an external port (debug/DMA loader) with round-robin fairness. It latches the winning request, drives the DM for a fixed `LAT`-cycle access, and returns read data with a one-cycle acknowledge. While a CPU access is outstanding it raises `cpu_stall` so the hazard unit freezes IF/ID/EX/MEM.

## Interface
- `LAT`, 1: DM access latency in cycles, range 1..7. With 1, `mem_rd` is valid in the same cycle as `mem_en`, which is the current combinational-read DM.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: MEM stage holds a load/store. It stays high until `cpu_ack`.
- `cpu_we` in 1: store.
- `cpu_addr` in 32: byte address (ALU result).
- `cpu_wd` in 32: store data, after forwarding.
- `cpu_ctrl` in 3: DMCtrl width/sign encoding, passed through unchanged.
- `cpu_pc` in 32: PC of the instruction, used for the DM write log.
- `cpu_ack` out 1: one-cycle pulse when the CPU access is complete.
- `cpu_rd` out 32: load data. It is valid with `cpu_ack` and held until the next CPU ack.
- `cpu_stall` out 1: the CPU access is not yet acknowledged.
- `ext_req`, `ext_we`, `ext_addr[31:0]`, `ext_wd[31:0]`, `ext_ctrl[2:0]` in: external requester, same meaning as the CPU fields. `ext_pc` is not used and `mem_pc` is driven to 0 for external grants.
- `ext_ack` out 1, `ext_rd` out 32: same behaviour as the CPU outputs.
- `mem_en` out 1: DM access strobe.
- `mem_we` out 1: DM write enable. It is only asserted together with `mem_en`.
- `mem_addr` out 32, `mem_wd` out 32, `mem_ctrl` out 3, `mem_pc` out 32: latched request fields.
- `mem_rd` in 32: DM read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - A request present: grant it.
  - Both requests present: grant the port not served last (`last_grant`). The reset value is EXT, so the CPU wins the first tie.
  - On the grant edge: latch `we`/`addr`/`wd`/`ctrl`/`pc`, set `grant`, update `last_grant`, clear `cnt`, go to ACCESS.
- **ACCESS**
  - `mem_en` = (`cnt`==0). `mem_we` = `mem_en` & latched `we`.
  - `mem_addr`, `mem_wd`, `mem_ctrl` and `mem_pc` hold the latched values for the whole of ACCESS.
  - `cnt` increments each cycle.
  - When `cnt`==`LAT`-1: capture `mem_rd` into the granted port's rd register (a store captures 0), then go to RESP.
- **RESP**
  - Ack the granted port for exactly one cycle, then go to IDLE.
  - There is no re-grant in RESP.
- `cpu_stall` = `cpu_req` & ~`cpu_ack`. This is the only combinational output. All others decode registered state.
- Fairness: with both ports requesting continuously, grants alternate CPU, EXT, CPU, …. Neither port waits more than one foreign transaction.
- Requester drops `req` mid-transaction: the access still completes and the ack still pulses. The DM write is not cancelled.
- New request while the port is being served: ignored until IDLE.
- `cnt` is 3 bits. There is no wrap inside ACCESS because `LAT` ≤ 7.

## Timing
- Reset (`reset`=0, asynchronous):
  - State returns to IDLE, `cnt`=0, `last_grant`=EXT.
  - All outputs go to 0 immediately: `mem_en`, `mem_we`, acks, rd registers, `mem_*` fields.
  - An in-flight access is abandoned and no ack is issued.
  - `cpu_stall` follows `cpu_req` during reset.
- Request seen in IDLE at cycle 0:
  - `mem_en` in cycle 1.
  - rd captured at the end of cycle `LAT`.
  - ack in cycle `LAT`+1.
  - Request-to-ack latency is `LAT`+1 cycles.
- Back-to-back throughput: one access per `LAT`+2 cycles (IDLE, `LAT`×ACCESS, RESP).
- `mem_rd` is sampled only in the last ACCESS cycle. The DM must present valid data `LAT`-1 cycles after `mem_en`.
- An ack and a `req` drop may occur in the same cycle. The arbiter does not check that.

## Structure
- Package `dm_arb_pkg`:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - grant constants: GNT_CPU=1'b0, GNT_EXT=1'b1;
  - `DMCTRL_W`=3;
  - `LAT_MAX`=7.
- Sub-module `dm_arb_rr`: 2-way round-robin picker holding the `last_grant` register.
  - Inputs: `req[1:0]`, grant-enable.
  - Outputs: `gnt_valid`, `gnt_id`.
- The FSM, counter, request latch and rd registers live in `dm_arbiter`.

## Test plan
- **CPU load, `LAT`=2.** Stimulus: `cpu_req`=1, `we`=0, `addr`=0x0000_0010, DM returns 0xDEAD_BEEF. Required: `mem_en` in cycle 1 only, `cpu_ack` in cycle 3, `cpu_rd`=0xDEAD_BEEF, `cpu_stall` high in cycles 0–2.
- **EXT store, `LAT`=1.** Stimulus: `ext_we`=1, `addr`=0x24, `wd`=0x1234_5678, `ctrl`=3'b000. Required: one `mem_we` pulse with those exact fields, `mem_pc`=0, `ext_ack` in cycle 2, `ext_rd`=0.
- **Tie and fairness.** Stimulus: both ports request continuously for 4 transactions after reset. Required: grant order CPU, EXT, CPU, EXT, with acks 4 cycles apart at `LAT`=2.
- **Request drop.** Stimulus: `cpu_req` deasserted in cycle 1 of a store. Required: the write still occurs and `cpu_ack` still pulses in cycle 3.
- **Mid-access reset.** Stimulus: `reset` low in the second ACCESS cycle. Required: `mem_en`/`mem_we` go to 0 at once, no ack, IDLE after release, next tie goes to CPU.
- **`LAT`=7 boundary.** Stimulus: a single load. Required: ack exactly 8 cycles after the request, and `mem_rd` is sampled only in cycle 7.
